cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Run/debug sequencer for the pipelined 16-bit CPU. It owns the CPU's `enable` and a CPU-local reset. It sequences a clean start, free-run, pause/single-step, breakpoint stop, HALT-opcode detection with pipeline drain, and a cycle-budget timeout. It sits between the board/testbench control inputs and the CPU top. It watches the decode-stage opcode and PC exported by the datapath.

Parameters:
- `HALT_OP`, 4'hF, opcode value that ends a program.
- `CLR_CYCLES`, 2, cycles `cpu_rst` is held in CLEAR (range 1..15).
- `DRAIN_CYCLES`, 3, enabled cycles after HALT decode so EX/MEM/WB retire (range 1..15).
- `PC_W`, 8, PC / breakpoint width.

Ports:
- `clk`, in, 1, system clock.
- `reset`, in, 1, synchronous, active-high.
- `start`, in, 1, level-sampled: begin a run from IDLE/DONE, resume from PAUSE.
- `pause_req`, in, 1, request pause while running.
- `step`, in, 1, single-step request while paused.
- `opcode_d`, in, 4, decode-stage opcode from datapath.
- `opcode_vld`, in, 1, `opcode_d` is a real instruction (not a bubble/flush).
- `pc_d`, in, `PC_W`, PC of the decode-stage instruction.
- `bp_en`, in, 1, breakpoint enable.
- `bp_addr`, in, `PC_W`, breakpoint PC.
- `max_cycles`, in, 16, run budget; 0 = unlimited.
- `cpu_enable`, out, 1, drives CPU `enable`.
- `cpu_rst`, out, 1, drives CPU `reset`.
- `running`, out, 1, state is RUN or DRAIN.
- `paused`, out, 1, state is PAUSE.
- `done`, out, 1, state is DONE.
- `timeout`, out, 1, sticky: last run ended by budget.
- `halt_pc`, out, `PC_W`, PC of the HALT or breakpoint instruction that stopped execution.
- `cycle_count`, out, 16, enabled CPU cycles in the current run.

Behaviour:
- States: IDLE, CLEAR, RUN, PAUSE, DRAIN, DONE. All outputs are registered or pure state decode.
- `cpu_rst` = `reset` OR (state==CLEAR). It is the only combinational path.
- Reset: state IDLE; all outputs 0 except `cpu_rst`=1. Reset mid-run aborts immediately; no drain.
- IDLE: `cpu_enable`=0. `start` -> CLEAR. `step` and `pause_req` are ignored.
- CLEAR: `cpu_rst`=1 for exactly `CLR_CYCLES` cycles, then RUN.
  - `cycle_count`, `timeout` and `halt_pc` are cleared on entry.
- RUN: `cpu_enable`=1. `cycle_count` increments every cycle and saturates at 16'hFFFF. Exits are evaluated each cycle in priority order:
  1. `opcode_vld` && `opcode_d`==`HALT_OP` -> DRAIN; latch `halt_pc`=`pc_d`.
  2. `bp_en` && `pc_d`==`bp_addr` && not first RUN cycle after PAUSE -> PAUSE; latch `halt_pc`=`pc_d`.
  3. `pause_req` -> PAUSE.
  4. `max_cycles`!=0 && `cycle_count`+1==`max_cycles` -> DONE; `timeout`=1.
- The HALT instruction's own RUN cycle is counted.
- PAUSE: `cpu_enable`=0.
  - `step` (rising edge, edge-detected internally) -> `cpu_enable`=1 for exactly one cycle; `cycle_count` +1.
  - While paused, HALT in decode during that stepped cycle -> DRAIN.
  - `start` -> RUN; breakpoint masked for the first RUN cycle.
  - `start` and `step` in the same cycle: `start` wins.
- DRAIN: `cpu_enable`=1 for `DRAIN_CYCLES` cycles, counted. Breakpoint, pause and timeout are ignored. Then DONE.
- DONE: `cpu_enable`=0, `done`=1. All results are held. `start` -> CLEAR (rerun).
- A budget hit on the same cycle as a HALT decode drains; `timeout` stays 0.

Test Plan:
- Reset, then `start` pulse at cycle 0 -> `cpu_rst`=1 cycles 1-2, `cpu_enable`=1 from cycle 3, `running`=1.
- Program with HALT at PC 8'h05 decoded after 6 RUN cycles -> `halt_pc`=8'h05, enable 3 more cycles, `done`=1, `cycle_count`=9, `timeout`=0.
- `bp_en`=1, `bp_addr`=8'h03 -> `paused`=1 with `halt_pc`=8'h03. Two `step` pulses give exactly 2 single-cycle enables. `start` resumes without re-trapping at PC 3.
- `max_cycles`=10, no HALT -> `done`=1, `timeout`=1, `cycle_count`=10, `cpu_enable` low from cycle 11 of RUN.
- `pause_req` held in RUN -> enable drops next cycle and `step` works. `reset` asserted mid-DRAIN -> IDLE next cycle, all outputs 0, `cpu_rst`=1 during reset.
- HALT decode coincident with budget expiry (`max_cycles`=4, HALT on 4th RUN cycle) -> DRAIN taken, `timeout`=0, final `cycle_count`=7.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/debug sequencer for the pipelined 16-bit CPU.
// Owns CPU enable and local reset; handles start, pause/step, breakpoint, HALT drain, budget timeout.
module cpu_run_ctrl #(
    parameter logic [3:0] HALT_OP      = 4'hF,
    parameter int         CLR_CYCLES   = 2,
    parameter int         DRAIN_CYCLES = 3,
    parameter int         PC_W         = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            pause_req,
    input  logic            step,
    input  logic [3:0]      opcode_d,
    input  logic            opcode_vld,
    input  logic [PC_W-1:0] pc_d,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [15:0]     max_cycles,
    output logic            cpu_enable,
    output logic            cpu_rst,
    output logic            running,
    output logic            paused,
    output logic            done,
    output logic            timeout,
    output logic [PC_W-1:0] halt_pc,
    output logic [15:0]     cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_PAUSE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      clr_cnt_q, clr_cnt_d;
    logic [3:0]      drn_cnt_q, drn_cnt_d;
    logic            step_q, step_d;
    logic            step_prev_q;
    logic            resume_q, resume_d;
    logic            timeout_q, timeout_d;
    logic [PC_W-1:0] halt_pc_q, halt_pc_d;
    logic [15:0]     cycle_q, cycle_d;

    logic is_halt;
    logic bp_hit;
    logic budget_hit;
    logic step_rise;
    logic clear_res;

    assign is_halt    = opcode_vld && (opcode_d == HALT_OP);
    assign bp_hit     = bp_en && (pc_d == bp_addr) && !resume_q;
    assign budget_hit = (max_cycles != 16'd0) &&
                        (({1'b0, cycle_q} + 17'd1) == {1'b0, max_cycles});
    assign step_rise  = step && !step_prev_q;

    assign cpu_enable  = (state_q == S_RUN) || (state_q == S_DRAIN) ||
                         ((state_q == S_PAUSE) && step_q);
    assign cpu_rst     = reset || (state_q == S_CLEAR);
    assign running     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign paused      = (state_q == S_PAUSE);
    assign done        = (state_q == S_DONE);
    assign timeout     = timeout_q;
    assign halt_pc     = halt_pc_q;
    assign cycle_count = cycle_q;

    // Next-state sequencing, result latching and enabled-cycle counting.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        drn_cnt_d = drn_cnt_q;
        step_d    = 1'b0;
        resume_d  = 1'b0;
        timeout_d = timeout_q;
        halt_pc_d = halt_pc_q;
        cycle_d   = cycle_q;
        clear_res = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = 4'd0;
                    clear_res = 1'b1;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == 4'(CLR_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                end
            end
            S_RUN: begin
                if (is_halt) begin
                    state_d   = S_DRAIN;
                    halt_pc_d = pc_d;
                    drn_cnt_d = 4'd0;
                end else if (bp_hit) begin
                    state_d   = S_PAUSE;
                    halt_pc_d = pc_d;
                end else if (pause_req) begin
                    state_d = S_PAUSE;
                end else if (budget_hit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_PAUSE: begin
                if (step_q && is_halt) begin
                    state_d   = S_DRAIN;
                    halt_pc_d = pc_d;
                    drn_cnt_d = 4'd0;
                end else if (start) begin
                    state_d  = S_RUN;
                    resume_d = 1'b1;
                end else if (step_rise && !step_q) begin
                    step_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drn_cnt_q == 4'(DRAIN_CYCLES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drn_cnt_d = drn_cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_res) begin
            cycle_d   = 16'd0;
            timeout_d = 1'b0;
            halt_pc_d = '0;
        end else if (cpu_enable && (cycle_q != 16'hFFFF)) begin
            cycle_d = cycle_q + 16'd1;
        end
    end

    // State and result registers; reset aborts any run at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clr_cnt_q   <= 4'd0;
            drn_cnt_q   <= 4'd0;
            step_q      <= 1'b0;
            step_prev_q <= 1'b0;
            resume_q    <= 1'b0;
            timeout_q   <= 1'b0;
            halt_pc_q   <= '0;
            cycle_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            drn_cnt_q   <= drn_cnt_d;
            step_q      <= step_d;
            step_prev_q <= step;
            resume_q    <= resume_d;
            timeout_q   <= timeout_d;
            halt_pc_q   <= halt_pc_d;
            cycle_q     <= cycle_d;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: self-checking bench for cpu_run_ctrl.
// Table of vectors for the HALT run, hand sequences for step/breakpoint/budget corners.
module tb_cpu_run_ctrl;

    typedef struct packed {
        logic        en;
        logic        rs;
        logic        rn;
        logic        pa;
        logic        dn;
        logic        to;
        logic [7:0]  hpc;
        logic [15:0] cc;
    } out_t;

    typedef struct {
        logic       rst;
        logic       st;
        logic       pr;
        logic       sp;
        logic       vld;
        logic [3:0] op;
        logic [7:0] pc;
        out_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pause_req;
    logic        step;
    logic [3:0]  opcode_d;
    logic        opcode_vld;
    logic [7:0]  pc_d;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [15:0] max_cycles;
    logic        cpu_enable;
    logic        cpu_rst;
    logic        running;
    logic        paused;
    logic        done;
    logic        timeout;
    logic [7:0]  halt_pc;
    logic [15:0] cycle_count;

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];
    vec_t tbl[15];

    cpu_run_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause_req  (pause_req),
        .step       (step),
        .opcode_d   (opcode_d),
        .opcode_vld (opcode_vld),
        .pc_d       (pc_d),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .max_cycles (max_cycles),
        .cpu_enable (cpu_enable),
        .cpu_rst    (cpu_rst),
        .running    (running),
        .paused     (paused),
        .done       (done),
        .timeout    (timeout),
        .halt_pc    (halt_pc),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic en, input logic rs,
                                input logic rn, input logic pa,
                                input logic dn, input logic to,
                                input logic [7:0] hpc,
                                input logic [15:0] cc);
        out_t o;
        o = {en, rs, rn, pa, dn, to, hpc, cc};
        return o;
    endfunction

    function automatic vec_t v(input logic rst, input logic st,
                               input logic pr, input logic sp,
                               input logic vld, input logic [3:0] op,
                               input logic [7:0] pc, input out_t e);
        vec_t r;
        r.rst = rst;
        r.st  = st;
        r.pr  = pr;
        r.sp  = sp;
        r.vld = vld;
        r.op  = op;
        r.pc  = pc;
        r.exp = e;
        return r;
    endfunction

    // Push expectation, clock once, pop and compare just after the edge.
    task automatic tick(input string nm, input out_t e);
        out_t a;
        out_t x;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        a = {cpu_enable, cpu_rst, running, paused, done, timeout,
             halt_pc, cycle_count};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            x = exp_q.pop_front();
            if (a !== x) begin
                errors++;
                $display("FAIL %s: got en%b rst%b run%b pau%b dn%b to%b hpc=%h cc=%0d want en%b rst%b run%b pau%b dn%b to%b hpc=%h cc=%0d",
                         nm, a.en, a.rs, a.rn, a.pa, a.dn, a.to, a.hpc, a.cc,
                         x.en, x.rs, x.rn, x.pa, x.dn, x.to, x.hpc, x.cc);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        pause_req  = 1'b0;
        step       = 1'b0;
        opcode_d   = 4'h0;
        opcode_vld = 1'b0;
        pc_d       = 8'h00;
        bp_en      = 1'b1;
        bp_addr    = 8'h05;
        max_cycles = 16'd0;

        tbl[0]  = v(1, 0, 0, 0, 0, 4'h0, 8'h00, mk(0, 1, 0, 0, 0, 0, 8'h00, 0));
        tbl[1]  = v(0, 0, 1, 1, 0, 4'h0, 8'h00, mk(0, 0, 0, 0, 0, 0, 8'h00, 0));
        tbl[2]  = v(0, 1, 0, 0, 0, 4'h0, 8'h00, mk(0, 1, 0, 0, 0, 0, 8'h00, 0));
        tbl[3]  = v(0, 0, 0, 0, 0, 4'h0, 8'h00, mk(0, 1, 0, 0, 0, 0, 8'h00, 0));
        tbl[4]  = v(0, 0, 0, 0, 0, 4'h0, 8'h00, mk(1, 0, 1, 0, 0, 0, 8'h00, 0));
        tbl[5]  = v(0, 0, 0, 0, 1, 4'h1, 8'h00, mk(1, 0, 1, 0, 0, 0, 8'h00, 1));
        tbl[6]  = v(0, 0, 0, 0, 1, 4'h1, 8'h01, mk(1, 0, 1, 0, 0, 0, 8'h00, 2));
        tbl[7]  = v(0, 0, 0, 0, 1, 4'h1, 8'h02, mk(1, 0, 1, 0, 0, 0, 8'h00, 3));
        tbl[8]  = v(0, 0, 0, 0, 1, 4'h1, 8'h03, mk(1, 0, 1, 0, 0, 0, 8'h00, 4));
        tbl[9]  = v(0, 0, 0, 0, 1, 4'h1, 8'h04, mk(1, 0, 1, 0, 0, 0, 8'h00, 5));
        tbl[10] = v(0, 0, 0, 0, 1, 4'hF, 8'h05, mk(1, 0, 1, 0, 0, 0, 8'h05, 6));
        tbl[11] = v(0, 0, 0, 0, 1, 4'hF, 8'h05, mk(1, 0, 1, 0, 0, 0, 8'h05, 7));
        tbl[12] = v(0, 0, 1, 0, 0, 4'h0, 8'h05, mk(1, 0, 1, 0, 0, 0, 8'h05, 8));
        tbl[13] = v(0, 0, 0, 0, 0, 4'h0, 8'h05, mk(0, 0, 0, 0, 1, 0, 8'h05, 9));
        tbl[14] = v(0, 0, 0, 1, 0, 4'h0, 8'h05, mk(0, 0, 0, 0, 1, 0, 8'h05, 9));

        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            reset      = tbl[i].rst;
            start      = tbl[i].st;
            pause_req  = tbl[i].pr;
            step       = tbl[i].sp;
            opcode_vld = tbl[i].vld;
            opcode_d   = tbl[i].op;
            pc_d       = tbl[i].pc;
            tick($sformatf("halt_run[%0d]", i), tbl[i].exp);
        end

        // Breakpoint, single step, resume mask, pause_req, reset in drain.
        bp_addr = 8'h03;
        step = 0; pause_req = 0; opcode_vld = 0; pc_d = 8'h00;
        start = 1;
        tick("bp_clear0", mk(0, 1, 0, 0, 0, 0, 8'h00, 0));
        start = 0;
        tick("bp_clear1", mk(0, 1, 0, 0, 0, 0, 8'h00, 0));
        tick("bp_run0", mk(1, 0, 1, 0, 0, 0, 8'h00, 0));
        opcode_vld = 1; opcode_d = 4'h1;
        for (int k = 0; k < 3; k++) begin
            pc_d = 8'(k);
            tick($sformatf("bp_run_pc%0d", k),
                 mk(1, 0, 1, 0, 0, 0, 8'h00, 16'(k + 1)));
        end
        pc_d = 8'h03;
        tick("bp_trap", mk(0, 0, 0, 1, 0, 0, 8'h03, 4));
        step = 1;
        tick("step1_on", mk(1, 0, 0, 1, 0, 0, 8'h03, 4));
        step = 0;
        tick("step1_off", mk(0, 0, 0, 1, 0, 0, 8'h03, 5));
        pc_d = 8'h04; step = 1;
        tick("step2_on", mk(1, 0, 0, 1, 0, 0, 8'h03, 5));
        tick("step2_held", mk(0, 0, 0, 1, 0, 0, 8'h03, 6));
        step = 0;
        tick("step2_off", mk(0, 0, 0, 1, 0, 0, 8'h03, 6));
        pc_d = 8'h03; start = 1;
        tick("resume", mk(1, 0, 1, 0, 0, 0, 8'h03, 6));
        start = 0;
        tick("bp_masked", mk(1, 0, 1, 0, 0, 0, 8'h03, 7));
        pc_d = 8'h04;
        tick("run_pc4", mk(1, 0, 1, 0, 0, 0, 8'h03, 8));
        pc_d = 8'h03;
        tick("bp_retrap", mk(0, 0, 0, 1, 0, 0, 8'h03, 9));
        start = 1; step = 1; pc_d = 8'h05;
        tick("start_wins", mk(1, 0, 1, 0, 0, 0, 8'h03, 9));
        start = 0; step = 0; pause_req = 1;
        tick("pause_req", mk(0, 0, 0, 1, 0, 0, 8'h03, 10));
        step = 1;
        tick("step3_on", mk(1, 0, 0, 1, 0, 0, 8'h03, 10));
        step = 0;
        tick("step3_off", mk(0, 0, 0, 1, 0, 0, 8'h03, 11));
        step = 1;
        tick("step4_on", mk(1, 0, 0, 1, 0, 0, 8'h03, 11));
        step = 0; opcode_d = 4'hF; pc_d = 8'h07;
        tick("step_halt", mk(1, 0, 1, 0, 0, 0, 8'h07, 12));
        pause_req = 0; opcode_vld = 0; reset = 1;
        tick("rst_drain", mk(0, 1, 0, 0, 0, 0, 8'h00, 0));
        reset = 0;
        tick("post_rst", mk(0, 0, 0, 0, 0, 0, 8'h00, 0));

        // Budget expiry with no HALT.
        bp_en = 0; max_cycles = 16'd10; start = 1;
        tick("bud_clear0", mk(0, 1, 0, 0, 0, 0, 8'h00, 0));
        start = 0;
        tick("bud_clear1", mk(0, 1, 0, 0, 0, 0, 8'h00, 0));
        tick("bud_run0", mk(1, 0, 1, 0, 0, 0, 8'h00, 0));
        for (int i = 1; i < 10; i++) begin
            tick($sformatf("bud_run%0d", i),
                 mk(1, 0, 1, 0, 0, 0, 8'h00, 16'(i)));
        end
        tick("bud_done", mk(0, 0, 0, 0, 1, 1, 8'h00, 10));
        tick("bud_hold", mk(0, 0, 0, 0, 1, 1, 8'h00, 10));

        // HALT decode on the same cycle the budget expires.
        max_cycles = 16'd4; start = 1;
        tick("co_clear0", mk(0, 1, 0, 0, 0, 0, 8'h00, 0));
        start = 0;
        tick("co_clear1", mk(0, 1, 0, 0, 0, 0, 8'h00, 0));
        tick("co_run0", mk(1, 0, 1, 0, 0, 0, 8'h00, 0));
        for (int i = 1; i < 4; i++) begin
            tick($sformatf("co_run%0d", i),
                 mk(1, 0, 1, 0, 0, 0, 8'h00, 16'(i)));
        end
        opcode_vld = 1; opcode_d = 4'hF; pc_d = 8'h09;
        tick("co_halt", mk(1, 0, 1, 0, 0, 0, 8'h09, 4));
        opcode_vld = 0;
        tick("co_drain1", mk(1, 0, 1, 0, 0, 0, 8'h09, 5));
        tick("co_drain2", mk(1, 0, 1, 0, 0, 0, 8'h09, 6));
        tick("co_done", mk(0, 0, 0, 0, 1, 0, 8'h09, 7));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
